boot_ctrl: RTL

BOOT_CTRL -- requirements
Module: boot_ctrl

---
 rtl/boot_ctrl_pkg.sv | 40 ++++
 rtl/boot_word_asm.sv | 38 +++
 rtl/boot_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/boot_ctrl_pkg.sv
// Boot loader shared types: FSM states, stream constants, output flags.
// BOOT_CHECKSUM_EN adds the S_CHK trailer state.
package boot_ctrl_pkg;

    localparam int HDR_LEN        = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
`ifdef BOOT_CHECKSUM_EN
        S_CHK  = 3'd3,
`endif
        S_RUN  = 3'd4,
        S_ERR  = 3'd5
    } state_e;

    typedef struct packed {
        logic ready;
        logic core_reset;
        logic done;
        logic err;
    } flags_t;

    localparam flags_t FLAGS_RST = '{
        ready: 1'b0, core_reset: 1'b1, done: 1'b0, err: 1'b0
    };

    function automatic flags_t flags_of(input state_e s);
        flags_t f;
        f.ready      = (s != S_RUN) && (s != S_ERR);
        f.core_reset = (s != S_RUN);
        f.done       = (s == S_RUN);
        f.err        = (s == S_ERR);
        return f;
    endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Byte-to-word assembler: little-endian shift register and byte counter.
// Raises word_vld for one cycle after the last byte of a word.
module boot_word_asm
    import boot_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  data,
    output logic        last,
    output logic        word_vld,
    output logic [31:0] word
);

    logic [IDX_W-1:0] idx;

    assign last = (idx == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx      <= '0;
            word     <= '0;
            word_vld <= 1'b0;
        end else if (clear) begin
            idx      <= '0;
            word_vld <= 1'b0;
        end else begin
            word_vld <= push && last;
            if (push) begin
                // first byte drifts down to bits 7:0
                word <= {data, word[31:8]};
                idx  <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/boot_ctrl.sv
// Boot controller: streams a length-prefixed image into instruction memory.
// BOOT_CHECKSUM_EN adds an 8-bit zero-sum trailer check before release.
module boot_ctrl
    import boot_ctrl_pkg::*;
#(
    parameter int IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        boot_req,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        core_reset,
    output logic        boot_done,
    output logic        boot_err,
    output logic [15:0] word_cnt
);

    localparam logic [16:0] MAX_WORDS = 17'(IMEM_WORDS);
`ifdef BOOT_CHECKSUM_EN
    localparam state_e S_END = S_CHK;
`else
    localparam state_e S_END = S_RUN;
`endif

    state_e      state;
    state_e      state_d;
    flags_t      flags;
    logic [15:0] len_q;
    logic [15:0] n_hdr;
    logic        accept;
    logic        push;
    logic        last;
    logic        img_done;

    assign in_ready   = flags.ready & ~boot_req;
    assign core_reset = flags.core_reset;
    assign boot_done  = flags.done;
    assign boot_err   = flags.err;

    assign accept   = in_valid & in_ready;
    assign n_hdr    = {in_data, len_q[7:0]};
    assign img_done = (word_cnt == len_q);
    assign push     = accept && (state == S_DATA) && !img_done;

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] csum;
    logic       sum_ok;
    assign sum_ok = (8'(csum + in_data) == 8'h00);
`endif

    boot_word_asm u_asm (
        .clk      (clk),
        .reset    (reset),
        .clear    (boot_req),
        .push     (push),
        .data     (in_data),
        .last     (last),
        .word_vld (imem_we),
        .word     (imem_wd)
    );

    always_comb begin
        state_d = state;
        if (boot_req) begin
            state_d = S_LEN0;
        end else begin
            unique case (state)
                S_LEN0: if (accept) state_d = S_LEN1;
                S_LEN1: if (accept) begin
                    if ({1'b0, n_hdr} > MAX_WORDS) state_d = S_ERR;
                    else if (n_hdr == 16'd0)       state_d = S_END;
                    else                           state_d = S_DATA;
                end
                // word_cnt reaches N in the final write cycle
                S_DATA: if (img_done) begin
`ifdef BOOT_CHECKSUM_EN
                    if (accept) state_d = sum_ok ? S_RUN : S_ERR;
                    else        state_d = S_CHK;
`else
                    state_d = S_RUN;
`endif
                end
`ifdef BOOT_CHECKSUM_EN
                S_CHK: if (accept) state_d = sum_ok ? S_RUN : S_ERR;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_LEN0;
            flags     <= FLAGS_RST;
            len_q     <= '0;
            word_cnt  <= '0;
            imem_addr <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state <= state_d;
            flags <= flags_of(state_d);
            if (boot_req) begin
                len_q    <= '0;
                word_cnt <= '0;
`ifdef BOOT_CHECKSUM_EN
                csum     <= '0;
`endif
            end else begin
                if (accept && state == S_LEN0) len_q[7:0]  <= in_data;
                if (accept && state == S_LEN1) len_q[15:8] <= in_data;
                if (push && last) begin
                    imem_addr <= {14'd0, word_cnt, 2'b00};
                    word_cnt  <= word_cnt + 16'd1;
                end
`ifdef BOOT_CHECKSUM_EN
                if (accept) csum <= 8'(csum + in_data);
`endif
            end
        end
    end

endmodule
